rps_match_scorer: RTL and testbench
===================================

// Module: rps_match_scorer
// PURPOSE
//  Consumes per-round rock/paper/scissors results (2-bit win code) and runs a
//  best-of match: tallies user/computer/draw rounds, detects match end and
//  reports the match winner. Sits downstream of the round judge, driven by a
//  one-cycle strobe marking each round result to be counted.
// PARAMETERS
//  WIN_TARGET  3   round wins needed to take the match (legal 1..15)
//  MAX_ROUNDS  9   scored-round cap incl. draws (legal 1..15, >= WIN_TARGET)
// PORTS
//  clk           in   1  clock, all state on rising edge
//  reset         in   1  asynchronous, active-low; 0 clears all state
//  start         in   1  begin a new match (level sampled per cycle)
//  win           in   2  round code: 00 user wins, 01 draw, 11 computer wins, 10 illegal
//  win_valid     in   1  one-cycle strobe: count win this cycle
//  user_score    out  4  rounds won by user
//  cpu_score     out  4  rounds won by computer
//  draw_count    out  4  drawn rounds
//  round_count   out  4  scored rounds (user+cpu+draw)
//  in_play       out  1  high while state == PLAY
//  match_over    out  1  high while state == OVER
//  match_winner  out  2  00 user, 11 computer, 01 tie, 10 no result
//  err           out  1  sticky: illegal code (10) strobed during PLAY
// BEHAVIOUR
//  - Reset (reset==0): state IDLE; all counters 0; in_play=0, match_over=0,
//    match_winner=10, err=0. Takes effect immediately, including mid-match.
//  - All outputs registered; counters/flags update on the edge that samples
//    win_valid (1-cycle latency, visible the cycle after the strobe).
//  - FSM IDLE -> PLAY -> OVER:
//    IDLE: win_valid ignored. start=1 -> PLAY; counters, err cleared,
//          match_winner=10.
//    PLAY: start ignored. On win_valid: 00 -> user_score+1; 11 -> cpu_score+1;
//          01 -> draw_count+1; each of these round_count+1. Code 10 -> err=1,
//          no counter changes, not a round.
//    PLAY -> OVER on the same edge the counting round makes:
//          user_score==WIN_TARGET -> match_winner=00;
//          cpu_score==WIN_TARGET  -> match_winner=11;
//          else round_count==MAX_ROUNDS -> winner by higher score, equal -> 01.
//          Target check takes priority over round cap on the same edge.
//    OVER: counters and match_winner held; win_valid ignored. start=1 -> PLAY
//          with full clear (err cleared too).
//  - start and win_valid on same IDLE/OVER cycle: start wins, strobe dropped.
//  - Counters never exceed 15 (bounded by parameters); no wrap logic needed.
//  - win is don't-care when win_valid=0.
// TESTING
//  1. Reset, start, 3 strobes win=00 -> user_score=3, match_over=1,
//     match_winner=00 one cycle after 3rd strobe; round_count=3.
//  2. Strobes 11,01,11,00,11 -> cpu 3, user 1, draw 1, round_count=5,
//     match_winner=11; further strobes leave counters unchanged.
//  3. 9 strobes win=01 -> draw_count=9, match_over=1, match_winner=01.
//  4. Strobe win=10 during PLAY -> err=1, round_count unchanged; err persists
//     until next start; strobes in IDLE -> no counter change.
//  5. Pull reset low mid-match with user_score=2 -> all outputs to reset
//     values without a clock edge; start after release begins at 0/0.
//  6. In OVER, start with win_valid=1, win=00 same cycle -> PLAY, all
//     counters 0 (strobe dropped).

Source files
------------

// File: rtl/rps_match_scorer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rps_match_scorer: best-of match tally and winner for RPS round codes  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module rps_match_scorer #(
  parameter int WIN_TARGET = 3,
  parameter int MAX_ROUNDS = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] win,
  input  logic       win_valid,
  output logic [3:0] user_score,
  output logic [3:0] cpu_score,
  output logic [3:0] draw_count,
  output logic [3:0] round_count,
  output logic       in_play,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic       err
);

  localparam logic [3:0] c_win_target = 4'(WIN_TARGET);
  localparam logic [3:0] c_max_rounds = 4'(MAX_ROUNDS);

  localparam logic [1:0] c_code_user = 2'b00;
  localparam logic [1:0] c_code_draw = 2'b01;
  localparam logic [1:0] c_code_bad  = 2'b10;
  localparam logic [1:0] c_code_cpu  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] user_q, user_d;
  logic [3:0] cpu_q, cpu_d;
  logic [3:0] draw_q, draw_d;
  logic [3:0] round_q, round_d;
  logic [1:0] winner_q, winner_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      user_q   <= 4'd0;
      cpu_q    <= 4'd0;
      draw_q   <= 4'd0;
      round_q  <= 4'd0;
      winner_q <= c_code_bad;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      user_q   <= user_d;
      cpu_q    <= cpu_d;
      draw_q   <= draw_d;
      round_q  <= round_d;
      winner_q <= winner_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    user_d   = user_q;
    cpu_d    = cpu_q;
    draw_d   = draw_q;
    round_d  = round_q;
    winner_d = winner_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE, S_OVER: begin
        // start always beats a coincident strobe; strobes are ignored here anyway
        if (start) begin
          state_d  = S_PLAY;
          user_d   = 4'd0;
          cpu_d    = 4'd0;
          draw_d   = 4'd0;
          round_d  = 4'd0;
          winner_d = c_code_bad;
          err_d    = 1'b0;
        end
      end

      S_PLAY: begin
        if (win_valid) begin
          case (win)
            c_code_user: user_d = user_q + 4'd1;
            c_code_cpu:  cpu_d  = cpu_q + 4'd1;
            c_code_draw: draw_d = draw_q + 4'd1;
            default:     err_d  = 1'b1;
          endcase

          if (win != c_code_bad) begin
            round_d = round_q + 4'd1;
            // Reaching the win target outranks hitting the round cap
            if (user_d == c_win_target) begin
              state_d  = S_OVER;
              winner_d = c_code_user;
            end else if (cpu_d == c_win_target) begin
              state_d  = S_OVER;
              winner_d = c_code_cpu;
            end else if (round_d == c_max_rounds) begin
              state_d = S_OVER;
              if (user_d > cpu_d) begin
                winner_d = c_code_user;
              end else if (cpu_d > user_d) begin
                winner_d = c_code_cpu;
              end else begin
                winner_d = c_code_draw;
              end
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign user_score   = user_q;
  assign cpu_score    = cpu_q;
  assign draw_count   = draw_q;
  assign round_count  = round_q;
  assign in_play      = (state_q == S_PLAY);
  assign match_over   = (state_q == S_OVER);
  assign match_winner = winner_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rps_match_scorer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_rps_match_scorer: directed self-checking bench for rps_match_scorer|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_rps_match_scorer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] win;
  logic       win_valid;
  logic [3:0] user_score;
  logic [3:0] cpu_score;
  logic [3:0] draw_count;
  logic [3:0] round_count;
  logic       in_play;
  logic       match_over;
  logic [1:0] match_winner;
  logic       err;

  int n_total;
  int n_bad;

  rps_match_scorer #(
    .WIN_TARGET(3),
    .MAX_ROUNDS(9)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .win         (win),
    .win_valid   (win_valid),
    .user_score  (user_score),
    .cpu_score   (cpu_score),
    .draw_count  (draw_count),
    .round_count (round_count),
    .in_play     (in_play),
    .match_over  (match_over),
    .match_winner(match_winner),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge; results are visible one falling edge later
  task automatic strobe(input logic [1:0] code);
    @(negedge clk);
    win       = code;
    win_valid = 1'b1;
    @(negedge clk);
    win_valid = 1'b0;
    win       = 2'bxx;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] u, input logic [3:0] c,
                         input logic [3:0] d, input logic [3:0] r, input logic ip,
                         input logic ov, input logic [1:0] w, input logic e);
    chk({tag, ".user"},   32'(user_score),   32'(u));
    chk({tag, ".cpu"},    32'(cpu_score),    32'(c));
    chk({tag, ".draw"},   32'(draw_count),   32'(d));
    chk({tag, ".round"},  32'(round_count),  32'(r));
    chk({tag, ".inplay"}, 32'(in_play),      32'(ip));
    chk({tag, ".over"},   32'(match_over),   32'(ov));
    chk({tag, ".winner"}, 32'(match_winner), 32'(w));
    chk({tag, ".err"},    32'(err),          32'(e));
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset     = 1'b0;
    start     = 1'b0;
    win       = 2'b00;
    win_valid = 1'b0;

    #12;
    chk_all("rst", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Strobes in IDLE must not count
    strobe(2'b00);
    strobe(2'b11);
    chk_all("idle", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b0);

    // User sweeps 3-0
    do_start();
    chk_all("t1.start", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    strobe(2'b00);
    strobe(2'b00);
    chk_all("t1.two", 4'd2, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 2'b10, 1'b0);
    strobe(2'b00);
    chk_all("t1.end", 4'd3, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 2'b00, 1'b0);

    // Computer wins 3-1 with one draw, then OVER holds
    do_start();
    strobe(2'b11);
    strobe(2'b01);
    strobe(2'b11);
    strobe(2'b00);
    chk_all("t2.mid", 4'd1, 4'd2, 4'd1, 4'd4, 1'b1, 1'b0, 2'b10, 1'b0);
    strobe(2'b11);
    chk_all("t2.end", 4'd1, 4'd3, 4'd1, 4'd5, 1'b0, 1'b1, 2'b11, 1'b0);
    strobe(2'b00);
    strobe(2'b10);
    chk_all("t2.hold", 4'd1, 4'd3, 4'd1, 4'd5, 1'b0, 1'b1, 2'b11, 1'b0);

    // Nine draws reach the round cap as a tie
    do_start();
    for (int i = 0; i < 8; i++) strobe(2'b01);
    chk_all("t3.eight", 4'd0, 4'd0, 4'd8, 4'd8, 1'b1, 1'b0, 2'b10, 1'b0);
    strobe(2'b01);
    chk_all("t3.end", 4'd0, 4'd0, 4'd9, 4'd9, 1'b0, 1'b1, 2'b01, 1'b0);

    // Round cap with user ahead 2-1
    do_start();
    strobe(2'b00);
    strobe(2'b00);
    strobe(2'b11);
    for (int i = 0; i < 6; i++) strobe(2'b01);
    chk_all("t3b.end", 4'd2, 4'd1, 4'd6, 4'd9, 1'b0, 1'b1, 2'b00, 1'b0);

    // Illegal code sets sticky err, is not a round
    do_start();
    strobe(2'b10);
    chk_all("t4.bad", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b10, 1'b1);
    strobe(2'b00);
    chk_all("t4.sticky", 4'd1, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 2'b10, 1'b1);
    strobe(2'b00);
    strobe(2'b00);
    chk_all("t4.over", 4'd3, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1, 2'b00, 1'b1);
    do_start();
    chk_all("t4.clr", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b10, 1'b0);

    // Asynchronous reset mid-match at user 2
    strobe(2'b00);
    strobe(2'b00);
    chk("t5.pre.user", 32'(user_score), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk_all("t5.async", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b10, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    do_start();
    strobe(2'b11);
    chk_all("t5.restart", 4'd0, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 2'b10, 1'b0);

    // start beats a coincident strobe in OVER
    strobe(2'b11);
    strobe(2'b11);
    chk("t6.pre.over", 32'(match_over), 32'd1);
    @(negedge clk);
    start     = 1'b1;
    win_valid = 1'b1;
    win       = 2'b00;
    @(negedge clk);
    start     = 1'b0;
    win_valid = 1'b0;
    chk_all("t6.restart", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b10, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
